// File: rtl/sdram_rw_arbiter.sv
// Burst request arbiter in front of the SDRAM command controller: picks write/read
// full-page bursts from FIFO levels and manages a ping-pong frame store.
module sdram_rw_arbiter #(
    parameter int unsigned BURST_LEN = 256,
    parameter int unsigned WR_THRESH = 256,
    parameter int unsigned RD_LOW    = 256,
    parameter int unsigned FIFO_AW   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sdram_init_done,
    input  logic [FIFO_AW-1:0] wfifo_usedw,
    input  logic [FIFO_AW-1:0] rfifo_usedw,
    input  logic               wr_frame_start,
    input  logic               rd_frame_start,
    input  logic               cmd_ack,
    output logic [1:0]         ctrl_cmd,
    output logic [21:0]        sys_addr,
    output logic               wr_buf_sel,
    output logic               rd_buf_sel,
    output logic               busy,
    output logic               wr_wrap_err
);

    typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ} state_t;

    localparam logic [21:0] STEP = 22'(BURST_LEN);

    state_t      state, state_nxt;
    logic [1:0]  cmd_nxt;
    logic [20:0] wr_off, rd_off, wr_off_n, rd_off_n;
    logic [21:0] wr_sum, rd_sum;
    logic        wr_buf_n, rd_buf_n, last_done, last_n;
    logic        wr_pend, rd_pend, wr_sync, rd_sync, apply, wr_ack, rd_ack, wrap;

    always_comb begin
        state_nxt = state;
        cmd_nxt   = 2'b00;
        case (state)
            IDLE: begin
                if (sdram_init_done) begin
                    if (32'(wfifo_usedw) >= WR_THRESH)   state_nxt = WR_REQ;
                    else if (32'(rfifo_usedw) <= RD_LOW) state_nxt = RD_REQ;
                end
            end
            WR_REQ, RD_REQ: if (cmd_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == WR_REQ)      cmd_nxt = 2'b01;
        else if (state_nxt == RD_REQ) cmd_nxt = 2'b10;
    end

    // Frame syncs take effect only when no request is outstanding (idle or on the
    // ack edge), after the offset increment, so sys_addr is frozen mid-request.
    always_comb begin
        wr_ack   = (state == WR_REQ) && cmd_ack;
        rd_ack   = (state == RD_REQ) && cmd_ack;
        apply    = (state == IDLE) || wr_ack || rd_ack;
        wr_sync  = apply && (wr_frame_start || wr_pend);
        rd_sync  = apply && (rd_frame_start || rd_pend);
        wr_sum   = {1'b0, wr_off} + STEP;
        rd_sum   = {1'b0, rd_off} + STEP;
        wrap     = wr_ack && wr_sum[21];
        wr_off_n = wr_sync ? '0 : (wr_ack ? wr_sum[20:0] : wr_off);
        rd_off_n = rd_sync ? '0 : (rd_ack ? rd_sum[20:0] : rd_off);
        wr_buf_n = wr_sync ? ~wr_buf_sel : wr_buf_sel;
        last_n   = wr_sync ? wr_buf_sel : last_done;
        rd_buf_n = rd_sync ? last_done : rd_buf_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ctrl_cmd    <= 2'b00;
            sys_addr    <= '0;
            busy        <= 1'b0;
            wr_wrap_err <= 1'b0;
            wr_buf_sel  <= 1'b0;
            rd_buf_sel  <= 1'b1;
            last_done   <= 1'b1;
            wr_off      <= '0;
            rd_off      <= '0;
            wr_pend     <= 1'b0;
            rd_pend     <= 1'b0;
        end else begin
            state       <= state_nxt;
            ctrl_cmd    <= cmd_nxt;
            busy        <= (state_nxt != IDLE);
            wr_wrap_err <= wr_wrap_err | wrap;
            wr_buf_sel  <= wr_buf_n;
            rd_buf_sel  <= rd_buf_n;
            last_done   <= last_n;
            wr_off      <= wr_off_n;
            rd_off      <= rd_off_n;
            wr_pend     <= apply ? 1'b0 : (wr_pend | wr_frame_start);
            rd_pend     <= apply ? 1'b0 : (rd_pend | rd_frame_start);
            if (state == IDLE && state_nxt == WR_REQ) sys_addr <= {wr_buf_n, wr_off_n};
            if (state == IDLE && state_nxt == RD_REQ) sys_addr <= {rd_buf_n, rd_off_n};
        end
    end

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Directed bench for sdram_rw_arbiter: a transaction-level frame-store model is
// compared every cycle, plus literal expectations for the key scenarios.
module tb_sdram_rw_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sdram_init_done = 1'b0;
    logic [9:0]  wfifo_usedw = '0;
    logic [9:0]  rfifo_usedw = 10'd500;
    logic        wr_frame_start = 1'b0;
    logic        rd_frame_start = 1'b0;
    logic        cmd_ack = 1'b0;
    logic [1:0]  ctrl_cmd;
    logic [21:0] sys_addr;
    logic        wr_buf_sel, rd_buf_sel, busy, wr_wrap_err;

    int n_chk = 0;
    int n_pass = 0;

    sdram_rw_arbiter dut (
        .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done),
        .wfifo_usedw(wfifo_usedw), .rfifo_usedw(rfifo_usedw),
        .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
        .cmd_ack(cmd_ack), .ctrl_cmd(ctrl_cmd), .sys_addr(sys_addr),
        .wr_buf_sel(wr_buf_sel), .rd_buf_sel(rd_buf_sel), .busy(busy),
        .wr_wrap_err(wr_wrap_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: e_cmd != 0 means a request is outstanding at e_addr.
    localparam int unsigned SPAN = 32'h0020_0000;
    logic [1:0]  e_cmd;
    logic [21:0] e_addr;
    logic        e_wb, e_rb, e_last, e_err, e_wp, e_rp;
    int unsigned e_woff, e_roff;

    always @(posedge clk or negedge rst_n) begin : model
        int unsigned wo, ro;
        logic wb, rb, lst, er, wp, rp;
        logic [1:0] cmd;
        logic [21:0] adr;
        if (!rst_n) begin
            e_cmd <= 0; e_addr <= 0; e_wb <= 0; e_rb <= 1; e_last <= 1;
            e_err <= 0; e_wp <= 0; e_rp <= 0; e_woff <= 0; e_roff <= 0;
        end else begin
            wo = e_woff; ro = e_roff; wb = e_wb; rb = e_rb; lst = e_last;
            er = e_err; wp = e_wp; rp = e_rp; cmd = e_cmd; adr = e_addr;
            if (e_cmd == 0 || cmd_ack) begin
                if (e_cmd == 1) begin
                    wo = wo + 256;
                    if (wo >= SPAN) begin wo = wo - SPAN; er = 1; end
                end else if (e_cmd == 2) begin
                    ro = (ro + 256) % SPAN;
                end
                cmd = 0;
                if (rd_frame_start || rp) begin rb = e_last; ro = 0; end
                if (wr_frame_start || wp) begin lst = e_wb; wb = !e_wb; wo = 0; end
                wp = 0; rp = 0;
                if (e_cmd == 0 && sdram_init_done) begin
                    if (wfifo_usedw >= 256) begin cmd = 1; adr = {wb, wo[20:0]}; end
                    else if (rfifo_usedw <= 256) begin cmd = 2; adr = {rb, ro[20:0]}; end
                end
            end else begin
                wp = wp | wr_frame_start;
                rp = rp | rd_frame_start;
            end
            e_woff <= wo; e_roff <= ro; e_wb <= wb; e_rb <= rb; e_last <= lst;
            e_err <= er; e_wp <= wp; e_rp <= rp; e_cmd <= cmd; e_addr <= adr;
        end
    end

    always @(negedge clk) begin
        chk("cmd", 32'(ctrl_cmd), 32'(e_cmd));
        chk("busy", 32'(busy), 32'(e_cmd != 0));
        chk("wr_buf_sel", 32'(wr_buf_sel), 32'(e_wb));
        chk("rd_buf_sel", 32'(rd_buf_sel), 32'(e_rb));
        chk("wrap_err", 32'(wr_wrap_err), 32'(e_err));
        if (e_cmd != 0) chk("addr", 32'(sys_addr), 32'(e_addr));
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic do_reset();
        rst_n = 0; cmd_ack = 0; wr_frame_start = 0; rd_frame_start = 0;
        step(2);
        rst_n = 1;
        step(1);
    endtask

    task automatic wait_req(input logic [1:0] c, input logic [21:0] a);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ctrl_cmd != 0) break;
        end
        chk("req_cmd", 32'(ctrl_cmd), 32'(c));
        chk("req_addr", 32'(sys_addr), 32'(a));
    endtask

    task automatic ack();
        step(1); cmd_ack = 1;
        step(1); cmd_ack = 0;
    endtask

    initial begin
        // Reset values, then init gating
        step(1);
        chk("rst_cmd", 32'(ctrl_cmd), 0);
        chk("rst_addr", 32'(sys_addr), 0);
        chk("rst_rbuf", 32'(rd_buf_sel), 1);
        chk("rst_wbuf", 32'(wr_buf_sel), 0);
        wfifo_usedw = 300; rfifo_usedw = 500;
        do_reset();
        step(5);
        chk("no_init_cmd", 32'(ctrl_cmd), 0);
        sdram_init_done = 1;
        step(1);
        chk("init_cmd", 32'(ctrl_cmd), 1);
        chk("init_addr", 32'(sys_addr), 0);
        wfifo_usedw = 0;
        ack();

        // Write priority, then read from buffer 1
        do_reset();
        wfifo_usedw = 256; rfifo_usedw = 0;
        wait_req(2'b01, 22'h000000);
        wfifo_usedw = 0;
        ack();
        wait_req(2'b10, 22'h200000);
        ack();
        wait_req(2'b10, 22'h200100);
        rfifo_usedw = 500;
        ack();

        // Three sequential writes, held stable against FIFO churn
        do_reset();
        rfifo_usedw = 500; wfifo_usedw = 300;
        for (int k = 0; k < 3; k++) begin
            wait_req(2'b01, 22'(k * 256));
            step(1); wfifo_usedw = 0;
            step(1); wfifo_usedw = 1000;
            chk("hold_cmd", 32'(ctrl_cmd), 1);
            wfifo_usedw = (k == 2) ? 10'd0 : 10'd300;
            ack();
        end

        // Frame syncs during a request, merged, then read-side swap
        wfifo_usedw = 300;
        wait_req(2'b01, 22'h000300);
        step(1); wr_frame_start = 1; step(1); wr_frame_start = 0;
        step(1); wr_frame_start = 1; step(1); wr_frame_start = 0;
        chk("sync_hold_addr", 32'(sys_addr), 32'h000300);
        chk("sync_hold_wbuf", 32'(wr_buf_sel), 0);
        ack();
        wait_req(2'b01, 22'h200000);
        chk("swap_wbuf", 32'(wr_buf_sel), 1);
        wfifo_usedw = 0;
        ack();
        step(2);
        rd_frame_start = 1; step(1); rd_frame_start = 0;
        chk("swap_rbuf", 32'(rd_buf_sel), 0);
        rfifo_usedw = 0;
        wait_req(2'b10, 22'h000000);
        rfifo_usedw = 500;
        ack();
        step(2);
        wr_frame_start = 1; rd_frame_start = 1; step(1);
        wr_frame_start = 0; rd_frame_start = 0;
        chk("both_wbuf", 32'(wr_buf_sel), 0);
        chk("both_rbuf", 32'(rd_buf_sel), 0);
        step(2);

        // Write offset wrap across the whole 2^21 span
        do_reset();
        rfifo_usedw = 500; wfifo_usedw = 300;
        for (int i = 0; i < 8192; i++) begin
            wait_req(2'b01, 22'(i * 256));
            if (i == 8191) begin
                chk("err_before_wrap", 32'(wr_wrap_err), 0);
                wfifo_usedw = 0;
            end
            ack();
        end
        chk("err_after_wrap", 32'(wr_wrap_err), 1);
        wfifo_usedw = 300;
        wait_req(2'b01, 22'h000000);
        wfifo_usedw = 0;
        ack();
        step(5);
        chk("err_sticky", 32'(wr_wrap_err), 1);

        // Reset in the middle of a read request
        do_reset();
        chk("err_cleared", 32'(wr_wrap_err), 0);
        wfifo_usedw = 0; rfifo_usedw = 0;
        wait_req(2'b10, 22'h200000);
        ack();
        wait_req(2'b10, 22'h200100);
        step(1);
        rst_n = 0;
        #1;
        chk("async_rst_cmd", 32'(ctrl_cmd), 0);
        chk("async_rst_busy", 32'(busy), 0);
        step(1);
        rst_n = 1;
        wait_req(2'b10, 22'h200000);
        rfifo_usedw = 500;
        ack();
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
